cameralink_frame_gen: RTL and testbench
=======================================

CAMERALINK_FRAME_GEN -- requirements
Module: cameralink_frame_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 640, meaning pixels per line (1..65535).
REQ-002 SHALL have parameter HEIGHT, default 480, meaning lines per frame (1..65535).
REQ-003 SHALL have parameter FSETUP, default 2, meaning cycles FVV is high before the first line (1..65535).
REQ-004 SHALL have parameter HBLANK, default 16, meaning LVV-low cycles between lines (1..65535).
REQ-005 SHALL have parameter VBLANK, default 4, meaning FVV-low cycles after a frame (1..65535).
REQ-006 SHALL have port CLOCK, input, 1, the single clock; all logic on rising edge.
REQ-007 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port cam_enable, input, 1, grabber enable; low blocks new frame starts.
REQ-009 SHALL have port cam_request, input, 1, single-frame trigger, rising-edge sensitive.
REQ-010 SHALL have port continuous, input, 1, free-run mode.
REQ-011 SHALL have port pix_rgb, input, 24, source pixel {blue,green,red}.
REQ-012 SHALL have port pix_stall, input, 1, source has no pixel this cycle.
REQ-013 SHALL have port pix_take, output, 1, combinational; pix_rgb consumed this cycle.
REQ-014 SHALL have ports FVV, LVV, VCE, output, 1 each, registered CameraLink timing.
REQ-015 SHALL have ports red, green, blue, output, 8 each, registered pixel data.
REQ-016 SHALL have port frame_done, output, 1, one-cycle registered pulse.
REQ-017 SHALL have port line_count, output, 16, index of current/last line (0-based).

Function
REQ-018 SHALL implement states IDLE, SETUP, ACTIVE, HBLANK, VBLANK.
REQ-019 IDLE: FVV=LVV=VCE=0; start when cam_enable=1 and (req_pending=1 or continuous=1) -> SETUP; req_pending cleared on that transition.
REQ-020 req_pending SHALL set on a cam_request 0->1 edge in any state; multiple edges before a start SHALL collapse to one frame.
REQ-021 SETUP: FVV=1, LVV=0 for exactly FSETUP cycles -> ACTIVE, line_count=0.
REQ-022 ACTIVE: FVV=1, LVV=1; pix_take = ~pix_stall; each take increments pixel counter.
REQ-023 On a take, next cycle SHALL show VCE=1 and red/green/blue = pix_rgb sampled at take (latency 1); otherwise VCE=0 and pixel outputs hold.
REQ-024 Stall SHALL keep LVV high and extend the line; a line lasts WIDTH plus the number of stalled cycles.
REQ-025 After the WIDTH-th take: if line_count < HEIGHT-1 -> HBLANK; else -> VBLANK.
REQ-026 HBLANK: FVV=1, LVV=0, for exactly HBLANK cycles, then line_count+1 and -> ACTIVE.
REQ-027 VBLANK: FVV=0, LVV=0 for exactly VBLANK cycles -> IDLE; frame_done=1 on the first VBLANK cycle only.
REQ-028 pix_take SHALL be 0 in every state except ACTIVE.
REQ-029 cam_enable or continuous dropping mid-frame SHALL NOT truncate the frame; it only gates the next IDLE start.
REQ-030 IDLE-to-SETUP SHALL take one cycle, so back-to-back frames have FVV low for VBLANK+1 cycles.
REQ-031 Counters SHALL be 16 bits and never wrap within legal parameter ranges.

Reset
REQ-032 RESET high SHALL immediately force IDLE, FVV=LVV=VCE=0, red=green=blue=0, frame_done=0, line_count=0, req_pending=0, counters 0.
REQ-033 RESET mid-frame SHALL abandon the frame with no frame_done; after release, start requires a new request edge or continuous.
REQ-034 cam_request edge detector SHALL reset its previous-value register to 0, so cam_request high at release counts as an edge.

Verification (WIDTH=4, HEIGHT=2, FSETUP=1, HBLANK=2, VBLANK=3)
REQ-035 Single frame, no stall, cam_enable=1, pulse cam_request -> FVV high 11 cycles, two LVV pulses of 4, 8 VCE pulses carrying pix_rgb, frame_done once, return to IDLE.
REQ-036 Stall 2 cycles mid-line 0 -> line 0 LVV high 6 cycles, VCE low on those 2, pixel order preserved, still 8 VCE total.
REQ-037 continuous=1 for 2 frames -> FVV low exactly 4 cycles between frames, two frame_done pulses.
REQ-038 cam_enable=0 with request pulse, then cam_enable=1 ten cycles later -> no FVV until enable, then exactly one frame.
REQ-039 Three cam_request edges during a frame -> exactly one further frame after VBLANK.
REQ-040 RESET asserted during line 1 -> all outputs 0 same cycle, no frame_done, stays IDLE after release with cam_request low.

Source files
------------

// File: rtl/cameralink_frame_gen.sv
// CameraLink frame generator: turns a stallable 24-bit pixel source into
// FVV/LVV/VCE framed video, started on request or free-running.
module cameralink_frame_gen #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int FSETUP = 2,
    parameter int HBLANK = 16,
    parameter int VBLANK = 4
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        cam_enable,
    input  logic        cam_request,
    input  logic        continuous,
    input  logic [23:0] pix_rgb,
    input  logic        pix_stall,
    output logic        pix_take,
    output logic        FVV,
    output logic        LVV,
    output logic        VCE,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_done,
    output logic [15:0] line_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HBLANK = 3'd3,
        ST_VBLANK = 3'd4
    } state_t;

    // Terminal counts: every phase counter runs 0 .. N-1.
    localparam logic [15:0] WIDTH_LAST  = 16'(WIDTH - 1);
    localparam logic [15:0] HEIGHT_LAST = 16'(HEIGHT - 1);
    localparam logic [15:0] FSETUP_LAST = 16'(FSETUP - 1);
    localparam logic [15:0] HBLANK_LAST = 16'(HBLANK - 1);
    localparam logic [15:0] VBLANK_LAST = 16'(VBLANK - 1);

    state_t      state_r;
    state_t      state_nx_s;
    logic [15:0] phase_cnt_r;
    logic [15:0] phase_cnt_nx_s;
    logic [15:0] pix_cnt_r;
    logic [15:0] pix_cnt_nx_s;
    logic [15:0] line_r;
    logic [15:0] line_nx_s;
    logic        req_prev_r;
    logic        req_pending_r;
    logic        req_edge_s;
    logic        start_s;
    logic        take_s;
    logic        fvv_nx_s;
    logic        lvv_nx_s;
    logic        fvv_r;
    logic        lvv_r;
    logic        vce_r;
    logic        frame_done_r;
    logic [7:0]  red_r;
    logic [7:0]  green_r;
    logic [7:0]  blue_r;

    // Source handshake: pixels are consumed only while a line is being driven.
    always_comb begin
        take_s = 1'b0;
        if (state_r == ST_ACTIVE) begin
            take_s = ~pix_stall;
        end else begin
            take_s = 1'b0;
        end
    end

    assign req_edge_s = cam_request & ~req_prev_r;

    // Next-state and counter update logic.
    always_comb begin
        state_nx_s     = state_r;
        phase_cnt_nx_s = phase_cnt_r;
        pix_cnt_nx_s   = pix_cnt_r;
        line_nx_s      = line_r;
        start_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cam_enable && (req_pending_r || continuous)) begin
                    state_nx_s     = ST_SETUP;
                    phase_cnt_nx_s = 16'd0;
                    start_s        = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (phase_cnt_r == FSETUP_LAST) begin
                    state_nx_s     = ST_ACTIVE;
                    phase_cnt_nx_s = 16'd0;
                    pix_cnt_nx_s   = 16'd0;
                    line_nx_s      = 16'd0;
                end else begin
                    phase_cnt_nx_s = phase_cnt_r + 16'd1;
                end
            end
            ST_ACTIVE: begin
                // Stalled cycles simply hold the line open.
                if (take_s) begin
                    if (pix_cnt_r == WIDTH_LAST) begin
                        pix_cnt_nx_s   = 16'd0;
                        phase_cnt_nx_s = 16'd0;
                        if (line_r < HEIGHT_LAST) begin
                            state_nx_s = ST_HBLANK;
                        end else begin
                            state_nx_s = ST_VBLANK;
                        end
                    end else begin
                        pix_cnt_nx_s = pix_cnt_r + 16'd1;
                    end
                end else begin
                    pix_cnt_nx_s = pix_cnt_r;
                end
            end
            ST_HBLANK: begin
                if (phase_cnt_r == HBLANK_LAST) begin
                    state_nx_s     = ST_ACTIVE;
                    phase_cnt_nx_s = 16'd0;
                    line_nx_s      = line_r + 16'd1;
                end else begin
                    phase_cnt_nx_s = phase_cnt_r + 16'd1;
                end
            end
            ST_VBLANK: begin
                if (phase_cnt_r == VBLANK_LAST) begin
                    state_nx_s     = ST_IDLE;
                    phase_cnt_nx_s = 16'd0;
                end else begin
                    phase_cnt_nx_s = phase_cnt_r + 16'd1;
                end
            end
            default: begin
                state_nx_s     = ST_IDLE;
                phase_cnt_nx_s = 16'd0;
                pix_cnt_nx_s   = 16'd0;
            end
        endcase
    end

    // Timing strobes decoded from the next state so they register in step with it.
    always_comb begin
        fvv_nx_s = 1'b0;
        lvv_nx_s = 1'b0;
        case (state_nx_s)
            ST_SETUP:  fvv_nx_s = 1'b1;
            ST_ACTIVE: begin
                fvv_nx_s = 1'b1;
                lvv_nx_s = 1'b1;
            end
            ST_HBLANK: fvv_nx_s = 1'b1;
            ST_IDLE:   fvv_nx_s = 1'b0;
            ST_VBLANK: fvv_nx_s = 1'b0;
            default: begin
                fvv_nx_s = 1'b0;
                lvv_nx_s = 1'b0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            phase_cnt_r <= 16'd0;
            pix_cnt_r   <= 16'd0;
            line_r      <= 16'd0;
        end else begin
            state_r     <= state_nx_s;
            phase_cnt_r <= phase_cnt_nx_s;
            pix_cnt_r   <= pix_cnt_nx_s;
            line_r      <= line_nx_s;
        end
    end

    // Request edge capture; a fresh edge wins over the clear at frame start.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            req_prev_r    <= 1'b0;
            req_pending_r <= 1'b0;
        end else begin
            req_prev_r <= cam_request;
            if (req_edge_s) begin
                req_pending_r <= 1'b1;
            end else if (start_s) begin
                req_pending_r <= 1'b0;
            end else begin
                req_pending_r <= req_pending_r;
            end
        end
    end

    // Registered CameraLink outputs and pixel pipeline stage.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            fvv_r        <= 1'b0;
            lvv_r        <= 1'b0;
            vce_r        <= 1'b0;
            frame_done_r <= 1'b0;
            red_r        <= 8'd0;
            green_r      <= 8'd0;
            blue_r       <= 8'd0;
        end else begin
            fvv_r        <= fvv_nx_s;
            lvv_r        <= lvv_nx_s;
            vce_r        <= take_s;
            frame_done_r <= (state_nx_s == ST_VBLANK) && (state_r != ST_VBLANK);
            if (take_s) begin
                red_r   <= pix_rgb[7:0];
                green_r <= pix_rgb[15:8];
                blue_r  <= pix_rgb[23:16];
            end else begin
                red_r   <= red_r;
                green_r <= green_r;
                blue_r  <= blue_r;
            end
        end
    end

    assign pix_take   = take_s;
    assign FVV        = fvv_r;
    assign LVV        = lvv_r;
    assign VCE        = vce_r;
    assign frame_done = frame_done_r;
    assign red        = red_r;
    assign green      = green_r;
    assign blue       = blue_r;
    assign line_count = line_r;

endmodule

// File: tb/tb_cameralink_frame_gen.sv
// Directed bench for cameralink_frame_gen: cycle table for two frames plus
// hand-written sequences for enable gating, free-run, request collapse and reset.
module tb_cameralink_frame_gen;

    logic        CLOCK;
    logic        RESET;
    logic        cam_enable;
    logic        cam_request;
    logic        continuous;
    logic [23:0] pix_rgb;
    logic        pix_stall;
    logic        pix_take;
    logic        FVV;
    logic        LVV;
    logic        VCE;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        frame_done;
    logic [15:0] line_count;

    cameralink_frame_gen #(
        .WIDTH (4),
        .HEIGHT(2),
        .FSETUP(1),
        .HBLANK(2),
        .VBLANK(3)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .cam_enable (cam_enable),
        .cam_request(cam_request),
        .continuous (continuous),
        .pix_rgb    (pix_rgb),
        .pix_stall  (pix_stall),
        .pix_take   (pix_take),
        .FVV        (FVV),
        .LVV        (LVV),
        .VCE        (VCE),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .frame_done (frame_done),
        .line_count (line_count)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic        req;
        logic        stall;
        logic [23:0] rgb;
        logic [44:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_miss;
    int   fvv_cnt;
    int   lvv_cnt;
    int   vce_cnt;
    int   fd_cnt;
    logic hist[0:59];

    localparam logic [23:0] J  = 24'hFFFFFF;
    localparam logic [23:0] P0 = 24'h302010, P1 = 24'h312111, P2 = 24'h322212, P3 = 24'h332313;
    localparam logic [23:0] P4 = 24'h342414, P5 = 24'h352515, P6 = 24'h362616, P7 = 24'h372717;
    localparam logic [23:0] Q0 = 24'h605040, Q1 = 24'h615141, Q2 = 24'h625242, Q3 = 24'h635343;
    localparam logic [23:0] Q4 = 24'h645444, Q5 = 24'h655545, Q6 = 24'h665646, Q7 = 24'h675747;

    // flags = {FVV, LVV, VCE, pix_take, frame_done}
    task automatic add(input logic r, input logic s, input logic [23:0] rgb,
                       input logic [4:0] flags, input logic [15:0] ln, input logic [23:0] px);
        vec_t v;
        v.req   = r;
        v.stall = s;
        v.rgb   = rgb;
        v.exp   = {flags, ln, px};
        vecs.push_back(v);
    endtask

    function automatic logic [44:0] actual();
        return {FVV, LVV, VCE, pix_take, frame_done, line_count, blue, green, red};
    endfunction

    task automatic check_vec(input string name, input logic [44:0] act, input logic [44:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        fvv_cnt = 0;
        lvv_cnt = 0;
        vce_cnt = 0;
        fd_cnt  = 0;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLOCK);
            fvv_cnt += int'(FVV);
            lvv_cnt += int'(LVV);
            vce_cnt += int'(VCE);
            fd_cnt  += int'(frame_done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_miss);
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx;
        int   start;
        int   gap;
        int   total;
        logic found;

        n_vec  = 0;
        n_miss = 0;
        RESET       = 1'b1;
        cam_enable  = 1'b1;
        cam_request = 1'b0;
        continuous  = 1'b0;
        pix_rgb     = 24'd0;
        pix_stall   = 1'b0;
        clear_counts();

        // Frame 1: plain; frame 2: two stall cycles in line 0.
        add(1'b1, 1'b0, J,  5'b00000, 16'd0, 24'd0);
        add(1'b0, 1'b0, J,  5'b00000, 16'd0, 24'd0);
        add(1'b0, 1'b0, J,  5'b10000, 16'd0, 24'd0);
        add(1'b0, 1'b0, P0, 5'b11010, 16'd0, 24'd0);
        add(1'b0, 1'b0, P1, 5'b11110, 16'd0, P0);
        add(1'b0, 1'b0, P2, 5'b11110, 16'd0, P1);
        add(1'b0, 1'b0, P3, 5'b11110, 16'd0, P2);
        add(1'b0, 1'b0, J,  5'b10100, 16'd0, P3);
        add(1'b0, 1'b1, J,  5'b10000, 16'd0, P3);
        add(1'b0, 1'b0, P4, 5'b11010, 16'd1, P3);
        add(1'b0, 1'b0, P5, 5'b11110, 16'd1, P4);
        add(1'b0, 1'b0, P6, 5'b11110, 16'd1, P5);
        add(1'b0, 1'b0, P7, 5'b11110, 16'd1, P6);
        add(1'b0, 1'b0, J,  5'b00101, 16'd1, P7);
        add(1'b0, 1'b0, J,  5'b00000, 16'd1, P7);
        add(1'b0, 1'b0, J,  5'b00000, 16'd1, P7);
        add(1'b1, 1'b0, J,  5'b00000, 16'd1, P7);
        add(1'b0, 1'b0, J,  5'b00000, 16'd1, P7);
        add(1'b0, 1'b0, J,  5'b10000, 16'd1, P7);
        add(1'b0, 1'b0, Q0, 5'b11010, 16'd0, P7);
        add(1'b0, 1'b1, J,  5'b11100, 16'd0, Q0);
        add(1'b0, 1'b1, J,  5'b11000, 16'd0, Q0);
        add(1'b0, 1'b0, Q1, 5'b11010, 16'd0, Q0);
        add(1'b0, 1'b0, Q2, 5'b11110, 16'd0, Q1);
        add(1'b0, 1'b0, Q3, 5'b11110, 16'd0, Q2);
        add(1'b0, 1'b0, J,  5'b10100, 16'd0, Q3);
        add(1'b0, 1'b0, J,  5'b10000, 16'd0, Q3);
        add(1'b0, 1'b0, Q4, 5'b11010, 16'd1, Q3);
        add(1'b0, 1'b0, Q5, 5'b11110, 16'd1, Q4);
        add(1'b0, 1'b0, Q6, 5'b11110, 16'd1, Q5);
        add(1'b0, 1'b0, Q7, 5'b11110, 16'd1, Q6);
        add(1'b0, 1'b0, J,  5'b00101, 16'd1, Q7);
        add(1'b0, 1'b0, J,  5'b00000, 16'd1, Q7);
        add(1'b0, 1'b0, J,  5'b00000, 16'd1, Q7);
        add(1'b0, 1'b0, J,  5'b00000, 16'd1, Q7);

        @(negedge CLOCK);
        @(negedge CLOCK);
        #1;
        check_vec("reset_state", actual(), 45'd0);
        RESET = 1'b0;
        @(negedge CLOCK);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLOCK);
            cam_request = vecs[i].req;
            pix_stall   = vecs[i].stall;
            pix_rgb     = vecs[i].rgb;
            #1;
            check_vec($sformatf("vec%0d", i), actual(), vecs[i].exp);
        end
        pix_stall = 1'b0;
        pix_rgb   = 24'h0A0B0C;

        // Request while disabled is held until enable.
        cycles(1);
        cam_enable  = 1'b0;
        cam_request = 1'b1;
        cycles(1);
        cam_request = 1'b0;
        clear_counts();
        cycles(10);
        check_int("gated_no_fvv", fvv_cnt, 0);
        cam_enable = 1'b1;
        clear_counts();
        cycles(40);
        check_int("gated_frame_done", fd_cnt, 1);
        check_int("gated_fvv_len", fvv_cnt, 11);
        check_int("gated_vce", vce_cnt, 8);
        check_int("gated_lvv", lvv_cnt, 8);

        // Free-run for two frames; dropping mode mid-frame must not truncate.
        continuous = 1'b1;
        fd_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLOCK);
            hist[i] = FVV;
            fd_cnt += int'(frame_done);
            if (i == 18) begin
                continuous = 1'b0;
                cam_enable = 1'b0;
            end
        end
        total = 0;
        for (int i = 0; i < 60; i++) total += int'(hist[i]);
        idx = 0;
        while (idx < 60 && hist[idx] == 1'b0) idx++;
        while (idx < 60 && hist[idx] == 1'b1) idx++;
        start = idx;
        while (idx < 60 && hist[idx] == 1'b0) idx++;
        gap = (idx < 60) ? idx - start : -1;
        check_int("cont_gap", gap, 4);
        check_int("cont_fvv_total", total, 22);
        check_int("cont_frame_done", fd_cnt, 2);
        cam_enable = 1'b1;

        // Several request edges during a frame collapse to one more frame.
        clear_counts();
        cam_request = 1'b1;
        cycles(1);
        cam_request = 1'b0;
        cycles(4);
        for (int p = 0; p < 3; p++) begin
            cam_request = 1'b1;
            cycles(1);
            cam_request = 1'b0;
            cycles(1);
        end
        cycles(60);
        check_int("collapse_frame_done", fd_cnt, 2);
        check_int("collapse_fvv_total", fvv_cnt, 22);

        // Reset during line 1 abandons the frame.
        cam_request = 1'b1;
        cycles(1);
        cam_request = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge CLOCK);
            if (LVV && line_count == 16'd1) found = 1'b1;
        end
        check_int("reset_line1_reached", int'(found), 1);
        #2;
        RESET = 1'b1;
        #1;
        check_vec("reset_async_clear", actual(), 45'd0);
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
        clear_counts();
        cycles(30);
        check_int("reset_no_fvv", fvv_cnt, 0);
        check_int("reset_no_frame_done", fd_cnt, 0);

        // Request held high across reset release counts as an edge.
        cam_request = 1'b1;
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        clear_counts();
        cycles(30);
        check_int("release_edge_frame_done", fd_cnt, 1);
        check_int("release_edge_fvv", fvv_cnt, 11);
        cam_request = 1'b0;
        cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
